// File: rtl/xram_pkg.sv
// -----------------------------------------------------------------------------
// xram_pkg
// Shared types and constants for the Xram wait-state responder.
//   xram_state_e : responder FSM states
//   LFSR_SEED    : value loaded into the jitter LFSR at reset
//   LFSR_TAPS    : feedback mask for x^8 + x^6 + x^5 + x^4 + 1
//   JIT_W        : width of the per-access jitter term (0..3 extra waits)
// -----------------------------------------------------------------------------
package xram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } xram_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Bits 7,5,4,3 correspond to polynomial terms x^8, x^6, x^5, x^4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         JIT_W     = 2;

endpackage

// File: rtl/xram_lfsr.sv
// -----------------------------------------------------------------------------
// xram_lfsr
// 8-bit Fibonacci LFSR used to jitter the number of wait states.
// Ports:
//   clk     in  clock
//   rst_n   in  async active-low reset (loads SEED)
//   en_i    in  advance one step this cycle
//   lfsr_o  out current LFSR state
// -----------------------------------------------------------------------------
module xram_lfsr
  import xram_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/xram_wait_responder.sv
// -----------------------------------------------------------------------------
// xram_wait_responder
// RAM-side responder for the Xram req/gnt/rvalid port. Inserts a programmable,
// optionally jittered number of wait states before raising ram_rready_o /
// ram_wready_o, and drives an external 1-cycle-latency single-port SRAM macro
// only in the grant cycle. Read data is returned the cycle after a read grant
// and held until the next read returns.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ram_en_i/addr/we/be/wdata   arbitrated request stream
//   ram_rready_o/ram_wready_o   read/write may be granted this cycle
//   ram_rdata_o                 read data (held)
//   cfg_rd_wait_i/cfg_wr_wait_i wait-state configuration (sampled when idle)
//   cfg_jitter_en_i             add 0..3 pseudo-random waits per access
//   busy_o                      request present but not granted
//   sram_*_o / sram_q_i         SRAM macro pins
// -----------------------------------------------------------------------------
module xram_wait_responder
  import xram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_W      = 4,
  parameter int RST_RD_WAIT = 1,
  parameter int RST_WR_WAIT = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ram_en_i,
  input  logic [ADDR_WIDTH-1:0]         ram_addr_i,
  input  logic                          ram_we_i,
  input  logic [DATA_WIDTH/8-1:0]       ram_be_i,
  input  logic [DATA_WIDTH-1:0]         ram_wdata_i,
  output logic                          ram_rready_o,
  output logic                          ram_wready_o,
  output logic [DATA_WIDTH-1:0]         ram_rdata_o,
  input  logic [WAIT_W-1:0]             cfg_rd_wait_i,
  input  logic [WAIT_W-1:0]             cfg_wr_wait_i,
  input  logic                          cfg_jitter_en_i,
  output logic                          busy_o,
  output logic                          sram_cs_o,
  output logic                          sram_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0]  sram_addr_o,
  output logic [DATA_WIDTH/8-1:0]       sram_be_o,
  output logic [DATA_WIDTH-1:0]         sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         sram_q_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int AL    = $clog2(BE_W);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  // One extra bit so target = max wait + max jitter fits.
  localparam int CNT_W = WAIT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((2 ** WAIT_W) - 1 + 3);

  xram_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [JIT_W-1:0]    jit_q, jit_d;
  logic [WAIT_W-1:0]   rd_wait_q, rd_wait_d;
  logic [WAIT_W-1:0]   wr_wait_q, wr_wait_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic [7:0]          lfsr;
  logic [JIT_W-1:0]    live_jit;
  logic [JIT_W-1:0]    cur_jit;
  logic [WAIT_W-1:0]   base_wait;
  logic [CNT_W-1:0]    tgt;
  logic                at_tgt;
  logic                grant;

  xram_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );

  // Target wait count. In WAIT the jitter captured at access start is reused,
  // while the base follows the current we so a requester switch mid-wait
  // retargets to the new access type. In IDLE/RESP cnt_q is 0, so at_tgt
  // reduces to "zero-wait access", giving a same-cycle combinational grant.
  always_comb begin
    live_jit  = cfg_jitter_en_i ? lfsr[JIT_W-1:0] : '0;
    cur_jit   = (state_q == WAIT) ? jit_q : live_jit;
    base_wait = ram_we_i ? wr_wait_q : rd_wait_q;
    tgt       = CNT_W'(base_wait) + CNT_W'(cur_jit);
    at_tgt    = (cnt_q >= tgt);
  end

  assign ram_rready_o = ram_en_i & ~ram_we_i & at_tgt;
  assign ram_wready_o = ram_en_i &  ram_we_i & at_tgt;
  assign grant        = ram_rready_o | ram_wready_o;
  assign busy_o       = ram_en_i & ~grant;

  // The macro is touched only in the grant cycle; the fields come straight
  // from the inputs so whichever requester is present at grant wins.
  assign sram_cs_o    = grant;
  assign sram_we_o    = ram_we_i;
  assign sram_addr_o  = ram_addr_i[AL +: IDX_W];
  assign sram_be_o    = ram_be_i;
  assign sram_wdata_o = ram_wdata_i;

  assign ram_rdata_o  = (state_q == RESP) ? sram_q_i : hold_q;

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    jit_d     = jit_q;
    rd_wait_d = rd_wait_q;
    wr_wait_d = wr_wait_q;
    hold_d    = hold_q;

    // Config only changes between accesses, never while one is pending.
    if (state_q == IDLE && !ram_en_i) begin
      rd_wait_d = cfg_rd_wait_i;
      wr_wait_d = cfg_wr_wait_i;
    end

    if (state_q == RESP) begin
      hold_d = sram_q_i;
    end

    case (state_q)
      IDLE, RESP: begin
        // A request arriving during RESP is treated exactly like one in IDLE.
        cnt_d   = '0;
        state_d = IDLE;
        if (ram_en_i) begin
          if (grant) begin
            state_d = ram_we_i ? IDLE : RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
            jit_d   = live_jit;
          end
        end
      end
      WAIT: begin
        if (!ram_en_i) begin
          // Withdrawal: abandon the access without touching the macro.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (grant) begin
          state_d = ram_we_i ? IDLE : RESP;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      jit_q     <= '0;
      rd_wait_q <= WAIT_W'(RST_RD_WAIT);
      wr_wait_q <= WAIT_W'(RST_WR_WAIT);
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      jit_q     <= jit_d;
      rd_wait_q <= rd_wait_d;
      wr_wait_q <= wr_wait_d;
      hold_q    <= hold_d;
    end
  end

  // Only the low LFSR bits feed jitter and only the word-index slice of the
  // byte address selects a macro row; the rest is intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{lfsr[7:JIT_W], ram_addr_i};

endmodule

// File: tb/tb_xram_wait_responder.sv
// -----------------------------------------------------------------------------
// tb_xram_wait_responder
// Directed bench for xram_wait_responder with a behavioural 1-cycle SRAM
// model and a small reference memory for the randomized jitter phase.
// -----------------------------------------------------------------------------
module tb_xram_wait_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_en_i;
  logic [31:0] ram_addr_i;
  logic        ram_we_i;
  logic [3:0]  ram_be_i;
  logic [31:0] ram_wdata_i;
  logic        ram_rready_o;
  logic        ram_wready_o;
  logic [31:0] ram_rdata_o;
  logic [3:0]  cfg_rd_wait_i;
  logic [3:0]  cfg_wr_wait_i;
  logic        cfg_jitter_en_i;
  logic        busy_o;
  logic        sram_cs_o;
  logic        sram_we_o;
  logic [11:0] sram_addr_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_q;

  // Preload port into the SRAM model, so the model array has one writer.
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [32];

  int n_checks = 0;
  int n_errors = 0;
  int cs_cnt   = 0;
  int bad_ready = 0;

  always #5 clk = ~clk;

  xram_wait_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ram_en_i        (ram_en_i),
    .ram_addr_i      (ram_addr_i),
    .ram_we_i        (ram_we_i),
    .ram_be_i        (ram_be_i),
    .ram_wdata_i     (ram_wdata_i),
    .ram_rready_o    (ram_rready_o),
    .ram_wready_o    (ram_wready_o),
    .ram_rdata_o     (ram_rdata_o),
    .cfg_rd_wait_i   (cfg_rd_wait_i),
    .cfg_wr_wait_i   (cfg_wr_wait_i),
    .cfg_jitter_en_i (cfg_jitter_en_i),
    .busy_o          (busy_o),
    .sram_cs_o       (sram_cs_o),
    .sram_we_o       (sram_we_o),
    .sram_addr_o     (sram_addr_o),
    .sram_be_o       (sram_be_o),
    .sram_wdata_o    (sram_wdata_o),
    .sram_q_i        (sram_q)
  );

  // Behavioural single-port SRAM, 1-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (sram_cs_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
      end else begin
        sram_q <= mem[sram_addr_o];
      end
    end
  end

  // Mid-cycle monitor: macro selects and any ready raised without a request.
  always @(negedge clk) begin
    #2;
    if (sram_cs_o) cs_cnt++;
    if ((ram_rready_o | ram_wready_o) & ~ram_en_i) bad_ready++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ram_en_i = 1'b0;
    end
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = 12'(w);
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // One access: raise en, count cycles with ready low, take the grant, drop
  // en, and sample rdata in the following (response) cycle.
  // cfg_mid >= 0 changes cfg_rd_wait_i while the request is pending.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int cfg_mid,
                        output int waits, output logic [31:0] rd);
    @(negedge clk);
    ram_en_i    = 1'b1;
    ram_we_i    = we;
    ram_addr_i  = addr;
    ram_be_i    = be;
    ram_wdata_i = wd;
    if (cfg_mid >= 0) cfg_rd_wait_i = 4'(cfg_mid);
    #1;
    waits = 0;
    while (!(we ? ram_wready_o : ram_rready_o) && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    @(negedge clk);
    ram_en_i = 1'b0;
    #1;
    rd = ram_rdata_o;
  endtask

  initial begin
    int          waits;
    logic [31:0] rd;
    int          cs0;
    logic        we;
    int          w;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;

    rst_n           = 1'b0;
    ram_en_i        = 1'b0;
    ram_we_i        = 1'b0;
    ram_addr_i      = '0;
    ram_be_i        = '0;
    ram_wdata_i     = '0;
    cfg_rd_wait_i   = 4'd1;
    cfg_wr_wait_i   = 4'd0;
    cfg_jitter_en_i = 1'b0;
    pl_en           = 1'b0;
    pl_addr         = '0;
    pl_data         = '0;

    // Reset state
    #23;
    check("rst_rready", ram_rready_o, 0);
    check("rst_wready", ram_wready_o, 0);
    check("rst_rdata",  ram_rdata_o,  0);
    check("rst_busy",   busy_o,       0);
    check("rst_cs",     sram_cs_o,    0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: zero-wait read returns preloaded data next cycle, then holds it
    cfg_rd_wait_i = 4'd0;
    idle(2);
    preload(4, 32'hDEADBEEF);
    access(1'b0, 32'h10, 4'h0, 32'h0, -1, waits, rd);
    check("t1_waits", waits, 0);
    check("t1_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    check("t1_hold", ram_rdata_o, 32'hDEADBEEF);

    // 2: three read waits, exactly one macro select
    cfg_rd_wait_i = 4'd3;
    preload(16, 32'h12345678);
    idle(2);
    cs0 = cs_cnt;
    access(1'b0, 32'h40, 4'h0, 32'h0, -1, waits, rd);
    check("t2_waits", waits, 3);
    check("t2_rdata", rd, 32'h12345678);
    check("t2_cs_pulses", cs_cnt - cs0, 1);

    // 3: partial write keeps upper bytes; write leaves held rdata alone
    cfg_wr_wait_i = 4'd2;
    preload(8, 32'h11223344);
    idle(2);
    access(1'b1, 32'h20, 4'b0011, 32'hCAFEF00D, -1, waits, rd);
    check("t3_wr_waits", waits, 2);
    check("t3_hold_after_wr", rd, 32'h12345678);
    access(1'b0, 32'h20, 4'h0, 32'h0, -1, waits, rd);
    check("t3_rd_waits", waits, 3);
    check("t3_rdata", rd, 32'h1122F00D);

    // 4: withdrawal after two cycles, then a fresh full-length wait
    cfg_rd_wait_i = 4'd5;
    idle(2);
    cs0 = cs_cnt;
    @(negedge clk);
    ram_en_i   = 1'b1;
    ram_we_i   = 1'b0;
    ram_addr_i = 32'h40;
    #1;
    check("t4_busy", busy_o, 1);
    check("t4_rready_low", ram_rready_o, 0);
    @(negedge clk);
    @(negedge clk);
    ram_en_i = 1'b0;
    #1;
    check("t4_busy_drop", busy_o, 0);
    @(negedge clk);
    #1;
    check("t4_no_cs", cs_cnt - cs0, 0);
    check("t4_hold", ram_rdata_o, 32'h1122F00D);
    access(1'b0, 32'h40, 4'h0, 32'h0, -1, waits, rd);
    check("t4_restart_waits", waits, 5);
    check("t4_rdata", rd, 32'h12345678);

    // 5: config change while en is high only affects the next access
    cfg_rd_wait_i = 4'd1;
    idle(2);
    access(1'b0, 32'h10, 4'h0, 32'h0, 4, waits, rd);
    check("t5_old_cfg_waits", waits, 1);
    check("t5_rdata", rd, 32'hDEADBEEF);
    idle(2);
    access(1'b0, 32'h10, 4'h0, 32'h0, -1, waits, rd);
    check("t5_new_cfg_waits", waits, 4);

    // 6: jittered random traffic against a reference memory
    cfg_rd_wait_i   = 4'd2;
    cfg_wr_wait_i   = 4'd1;
    cfg_jitter_en_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      preload(i, ref_mem[i]);
    end
    idle(2);
    for (int n = 0; n < 1000; n++) begin
      we   = 1'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 31));
      // Random upper bits exercise address wrap; low bits are byte offset.
      addr = ($urandom & 32'hFFFF_C000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      access(we, addr, be, wd, -1, waits, rd);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
        end
        check("t6_wr_wait_1to4", (waits >= 1 && waits <= 4), 1);
      end else begin
        check("t6_rd_wait_2to5", (waits >= 2 && waits <= 5), 1);
        check("t6_rdata", rd, ref_mem[w]);
      end
    end
    idle(2);
    check("ready_without_en", bad_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
